// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for a 5-stage core with a multi-cycle mult/div unit.
// Generates the pipeline-register enables, bubbles and flush, and counts IF stall cycles.
module pipe_ctrl #(
    parameter int unsigned MUL_CYC = 4,
    parameter int unsigned DIV_CYC = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        cnt_clr,
    output logic        if_en,
    output logic        id_en,
    output logic        exe_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        id_flush,
    output logic        exe_bubble,
    output logic        mem_bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    // Counter preload is occupancy minus the start cycle and the MD_DONE cycle.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYC - 2);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYC - 2);

    state_e      state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        freeze;

    assign freeze    = mem_req & ~mem_ready;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        if_en      = 1'b1;
        id_en      = 1'b1;
        exe_en     = 1'b1;
        mem_en     = 1'b1;
        wb_en      = 1'b1;
        id_flush   = 1'b0;
        exe_bubble = 1'b0;
        mem_bubble = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;

        // The arithmetic unit keeps counting even while memory freezes the pipe.
        if (state_q == MD_BUSY && md_cnt_q != 6'd0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end

        case (state_q)
            RUN, MD_DONE: begin
                md_done = (state_q == MD_DONE);
                if (branch_taken) begin
                    id_flush = 1'b1;
                end else if (load_use) begin
                    if_en      = 1'b0;
                    id_en      = 1'b0;
                    exe_bubble = 1'b1;
                end
                if (!freeze) begin
                    if (md_start) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = md_is_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            MD_BUSY: begin
                md_busy    = 1'b1;
                if_en      = 1'b0;
                id_en      = 1'b0;
                exe_en     = 1'b0;
                mem_bubble = 1'b1;
                if (!freeze && md_cnt_q == 6'd0) begin
                    state_d = MD_DONE;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (freeze) begin
            if_en      = 1'b0;
            id_en      = 1'b0;
            exe_en     = 1'b0;
            mem_en     = 1'b0;
            wb_en      = 1'b0;
            id_flush   = 1'b0;
            exe_bubble = 1'b0;
            mem_bubble = 1'b0;
        end

        // Outputs stay in their benign idle values for the whole reset window.
        if (!rst_n) begin
            if_en      = 1'b1;
            id_en      = 1'b1;
            exe_en     = 1'b1;
            mem_en     = 1'b1;
            wb_en      = 1'b1;
            id_flush   = 1'b0;
            exe_bubble = 1'b0;
            mem_bubble = 1'b0;
            md_busy    = 1'b0;
            md_done    = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (!if_en && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int MUL_CYC = 4;
    localparam int DIV_CYC = 33;

    logic        clk;
    logic        rst_n;
    logic        load_use, branch_taken, md_start, md_is_div;
    logic        mem_req, mem_ready, cnt_clr;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic        id_flush, exe_bubble, mem_bubble, md_busy, md_done;
    logic [15:0] stall_cnt;
    logic [9:0]  outs;

    int errors = 0;
    int checks = 0;

    // Model state: unit occupied, busy cycles left (incl. current), done pending, stall count
    bit mBusy;
    int mLeft;
    bit mDone;
    int mStall;

    pipe_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use(load_use), .branch_taken(branch_taken),
        .md_start(md_start), .md_is_div(md_is_div),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_flush(id_flush), .exe_bubble(exe_bubble), .mem_bubble(mem_bubble),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    // Bit order: if,id,exe,mem,wb,flush,exe_bubble,mem_bubble,busy,done
    assign outs = {if_en, id_en, exe_en, mem_en, wb_en,
                   id_flush, exe_bubble, mem_bubble, md_busy, md_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_use = 0; branch_taken = 0; md_start = 0; md_is_div = 0;
        mem_req = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    function automatic logic [9:0] model_outs();
        logic [4:0] en;
        logic fl, eb, mb, bz, dn;
        bit frz;
        frz = mem_req && !mem_ready;
        en = 5'b11111; fl = 0; eb = 0; mb = 0; bz = 0; dn = 0;
        if (mBusy) begin
            en = 5'b00011; mb = 1; bz = 1;
        end else begin
            dn = mDone;
            if (branch_taken) fl = 1;
            else if (load_use) begin en = 5'b00111; eb = 1; end
        end
        if (frz) begin
            en = 5'b00000; fl = 0; eb = 0; mb = 0;
        end
        return {en, fl, eb, mb, bz, dn};
    endfunction

    task automatic model_step(input logic [9:0] expOuts);
        bit frz;
        frz = mem_req && !mem_ready;
        if (cnt_clr) mStall = 0;
        else if (!expOuts[9] && mStall < 65535) mStall++;
        if (mBusy) begin
            if (mLeft <= 1) begin
                if (!frz) begin mBusy = 0; mDone = 1; end
            end else begin
                mLeft--;
            end
        end else if (!frz) begin
            mDone = 0;
            if (md_start) begin
                mBusy = 1;
                mLeft = md_is_div ? DIV_CYC - 1 : MUL_CYC - 1;
            end
        end
    endtask

    task automatic test_reset();
        idle();
        load_use = 1; mem_req = 1; mem_ready = 0;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (outs !== 10'b11111_00000) begin
            errors++;
            $display("[TB] FAIL reset_outs: got %b expected %b", outs, 10'b11111_00000);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt);
        end
        tick();
        idle();
        rst_n = 1;
        tick();
        @(negedge clk);
        checks++;
        if (outs !== 10'b11111_00000 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL after_reset: got %b/%0d expected %b/0", outs, stall_cnt, 10'b11111_00000);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        cnt_clr = 1;
        tick();
        idle();
        load_use = 1;
        @(negedge clk);
        checks++;
        if (outs !== 10'b00111_01000) begin
            errors++;
            $display("[TB] FAIL load_use_outs: got %b expected %b", outs, 10'b00111_01000);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd1 || outs !== 10'b11111_00000) begin
            errors++;
            $display("[TB] FAIL load_use_after: got %0d/%b expected 1/%b", stall_cnt, outs, 10'b11111_00000);
        end
        tick();
    endtask

    task automatic test_branch();
        idle();
        branch_taken = 1; load_use = 1;
        @(negedge clk);
        checks++;
        if (outs !== 10'b11111_10000) begin
            errors++;
            $display("[TB] FAIL branch_load_use: got %b expected %b", outs, 10'b11111_10000);
        end
        tick();
        idle();
    endtask

    task automatic test_mul();
        logic [9:0] expSeq [0:5];
        expSeq = '{10'b11111_00000, 10'b00011_00110, 10'b00011_00110,
                   10'b00011_00110, 10'b11111_00001, 10'b11111_00000};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin md_start = 1; cnt_clr = 1; end
            if (i == 2) begin md_start = 1; md_is_div = 1; branch_taken = 1; end
            @(negedge clk);
            checks++;
            if (outs !== expSeq[i]) begin
                errors++;
                $display("[TB] FAIL mul_cycle%0d: got %b expected %b", i, outs, expSeq[i]);
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL mul_stall_cnt: got %0d expected 3", stall_cnt);
        end
        tick();
    endtask

    task automatic test_div();
        int busyN = 0;
        bit seenDone = 0;
        idle();
        md_start = 1; md_is_div = 1;
        @(negedge clk);
        tick();
        idle();
        for (int i = 0; i < 60 && !seenDone; i++) begin
            @(negedge clk);
            if (md_busy) busyN++;
            if (md_done) seenDone = 1;
            tick();
        end
        checks++;
        if (busyN != DIV_CYC - 1) begin
            errors++;
            $display("[TB] FAIL div_busy_cycles: got %0d expected %0d", busyN, DIV_CYC - 1);
        end
        checks++;
        if (!seenDone) begin
            errors++;
            $display("[TB] FAIL div_done_seen: got 0 expected 1");
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] expSeq [0:9];
        expSeq = '{10'b11111_00000, 10'b00011_00110, 10'b00011_00110, 10'b00011_00110,
                   10'b11111_00001, 10'b00011_00110, 10'b00011_00110, 10'b00011_00110,
                   10'b11111_00001, 10'b11111_00000};
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 0 || i == 4) md_start = 1;
            @(negedge clk);
            checks++;
            if (outs !== expSeq[i]) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", i, outs, expSeq[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_freeze_busy();
        logic [9:0] expSeq [0:8];
        expSeq = '{10'b11111_00000, 10'b00000_00010, 10'b00000_00010, 10'b00000_00010,
                   10'b00000_00010, 10'b00000_00010, 10'b00011_00110, 10'b11111_00001,
                   10'b11111_00000};
        for (int i = 0; i < 9; i++) begin
            idle();
            if (i == 0) md_start = 1;
            if (i >= 1 && i <= 5) begin mem_req = 1; mem_ready = 0; end
            if (i == 6) begin mem_req = 1; mem_ready = 1; end
            @(negedge clk);
            checks++;
            if (outs !== expSeq[i]) begin
                errors++;
                $display("[TB] FAIL freeze_busy_cycle%0d: got %b expected %b", i, outs, expSeq[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_freeze_done();
        logic [9:0] expSeq [0:10];
        expSeq = '{10'b11111_00000, 10'b00011_00110, 10'b00011_00110, 10'b00011_00110,
                   10'b00000_00001, 10'b00000_00001, 10'b00000_00001, 10'b00000_00001,
                   10'b00000_00001, 10'b11111_00001, 10'b11111_00000};
        for (int i = 0; i < 11; i++) begin
            idle();
            if (i == 0) md_start = 1;
            if (i >= 4 && i <= 8) begin mem_req = 1; mem_ready = 0; end
            if (i == 9) begin mem_req = 1; mem_ready = 1; end
            @(negedge clk);
            checks++;
            if (outs !== expSeq[i]) begin
                errors++;
                $display("[TB] FAIL freeze_done_cycle%0d: got %b expected %b", i, outs, expSeq[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_saturate();
        idle();
        load_use = 1;
        for (int i = 0; i < 65540; i++) tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL stall_saturate: got %h expected ffff", stall_cnt);
        end
        cnt_clr = 1;
        tick();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL stall_clear: got %h expected 0000", stall_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_div();
        bit doneSeen = 0;
        bit busySeen = 0;
        idle();
        md_start = 1; md_is_div = 1;
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        rst_n = 0;
        #1;
        checks++;
        if (outs !== 10'b11111_00000) begin
            errors++;
            $display("[TB] FAIL reset_mid_div: got %b expected %b", outs, 10'b11111_00000);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done) doneSeen = 1;
            if (md_busy) busySeen = 1;
            tick();
        end
        checks++;
        if (doneSeen || busySeen) begin
            errors++;
            $display("[TB] FAIL reset_abort: got done=%0d busy=%0d expected 0/0", doneSeen, busySeen);
        end
        @(negedge clk);
        checks++;
        if (outs !== 10'b11111_00000) begin
            errors++;
            $display("[TB] FAIL reset_resume_run: got %b expected %b", outs, 10'b11111_00000);
        end
        tick();
    endtask

    task automatic test_random();
        logic [9:0] expOuts;
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        mBusy = 0; mLeft = 0; mDone = 0; mStall = 0;
        for (int i = 0; i < 1500; i++) begin
            load_use     = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
            md_start     = ($urandom_range(0, 9) == 0);
            md_is_div    = ($urandom_range(0, 9) < 3);
            mem_req      = ($urandom_range(0, 9) < 3);
            mem_ready    = ($urandom_range(0, 1) == 0);
            cnt_clr      = ($urandom_range(0, 31) == 0);
            expOuts = model_outs();
            @(negedge clk);
            checks++;
            if (outs !== expOuts) begin
                errors++;
                $display("[TB] FAIL random_outs@%0d: got %b expected %b", i, outs, expOuts);
            end
            checks++;
            if (stall_cnt !== 16'(mStall)) begin
                errors++;
                $display("[TB] FAIL random_stall@%0d: got %0d expected %0d", i, stall_cnt, mStall);
            end
            model_step(expOuts);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_div();
        test_back_to_back();
        test_freeze_busy();
        test_freeze_done();
        test_reset_mid_div();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
- REQ-001: Parameter MUL_CYC, default 4, multiply occupancy of the EXE stage in cycles (legal range 2..63).
- REQ-002: Parameter DIV_CYC, default 33, divide occupancy of the EXE stage in cycles (legal range 2..63).
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: load_use  input  1  load-use hazard request from the stall detector; 1 means stall ID and bubble EXE.
- REQ-006: branch_taken  input  1  branch or jump resolved taken in EXE.
- REQ-007: md_start  input  1  EXE holds a mult/div instruction and requests the unit.
- REQ-008: md_is_div  input  1  qualifies md_start; 1 = divide, 0 = multiply.
- REQ-009: mem_req  input  1  MEM stage has an outstanding data-memory access.
- REQ-010: mem_ready  input  1  data memory completes the access this cycle.
- REQ-011: cnt_clr  input  1  synchronous clear of stall_cnt.
- REQ-012: if_en, id_en, exe_en, mem_en, wb_en  output  1 each  pipeline-register write enables.
- REQ-013: id_flush  output  1  replace the IF/ID contents with a NOP.
- REQ-014: exe_bubble  output  1  load a NOP into ID/EXE.
- REQ-015: mem_bubble  output  1  load a NOP into EXE/MEM.
- REQ-016: md_busy  output  1  mult/div unit occupied.
- REQ-017: md_done  output  1  one-cycle pulse; mult/div result valid.
- REQ-018: stall_cnt  output  16  count of cycles with if_en=0.

Function
- REQ-019: FSM states are RUN, MD_BUSY and MD_DONE; there is also a 6-bit down-counter md_cnt.
- REQ-020: The freeze condition is mem_req & ~mem_ready, evaluated combinationally in every state; while it holds, all five enables are 0, id_flush, exe_bubble and mem_bubble are 0, and the FSM state is held.
- REQ-021: During freeze, md_cnt still decrements; the arithmetic unit is independent of the pipeline registers.
- REQ-022: In RUN without freeze, all enables are 1 by default.
- REQ-023: In RUN with load_use=1 and branch_taken=0: if_en=id_en=0, exe_bubble=1, and exe_en, mem_en and wb_en are 1.
- REQ-024: In RUN or MD_DONE with branch_taken=1: id_flush=1, all enables are 1, and load_use is ignored because the dependent instruction is flushed.
- REQ-025: RUN to MD_BUSY occurs on md_start=1 with no freeze; md_cnt loads (md_is_div ? DIV_CYC : MUL_CYC) - 2, and branch_taken has priority over load_use in the same cycle.
- REQ-026: In MD_BUSY: if_en=id_en=exe_en=0, mem_en=wb_en=1, mem_bubble=1, md_busy=1, and md_cnt decrements each cycle.
- REQ-027: MD_BUSY to MD_DONE occurs when md_cnt==0, giving total EXE occupancy of MUL_CYC or DIV_CYC cycles, including the MD_DONE cycle.
- REQ-028: In MD_DONE: md_done=1, md_busy=0, and the enables are as in RUN; the next state is RUN.
- REQ-029: An md_start in MD_DONE is a back-to-back request; it reloads md_cnt and returns to MD_BUSY.
- REQ-030: If MD_DONE coincides with freeze, md_done stays 1 until the freeze lifts; the pulse is released only on an unfrozen cycle.
- REQ-031: md_start and branch_taken received in MD_BUSY are ignored.
- REQ-032: stall_cnt increments by 1 on every cycle with if_en=0 and saturates at 16'hFFFF.
- REQ-033: cnt_clr=1 sets stall_cnt to 0 on the next edge and wins over a simultaneous increment.

Reset
- REQ-034: On rst_n=0, asynchronously: state=RUN, md_cnt=0, stall_cnt=0.
- REQ-035: Outputs during reset: all enables 1, id_flush, exe_bubble, mem_bubble, md_busy and md_done 0.
- REQ-036: Reset asserted mid-MD_BUSY or mid-freeze aborts the operation with no md_done pulse.
- REQ-037: Operation resumes on the first rising edge after rst_n rises.

Verification
- REQ-038: load_use=1 for one cycle in RUN -> if_en=id_en=0 and exe_bubble=1 that cycle; stall_cnt goes 0 to 1.
- REQ-039: md_start=1 with md_is_div=0 -> md_busy=1 for 3 cycles, then md_done=1 for 1 cycle, then RUN; with md_is_div=1 -> 32 busy cycles, then done.
- REQ-040: mem_req=1 with mem_ready=0 for 5 cycles during a multiply -> all enables 0 for those 5 cycles and md_cnt keeps counting; md_done is held until mem_ready=1.
- REQ-041: branch_taken=1 and load_use=1 in the same cycle -> id_flush=1, exe_bubble=0, all enables 1.
- REQ-042: Force 65,540 cycles with if_en=0 -> stall_cnt=16'hFFFF; then cnt_clr=1 -> stall_cnt=0.
- REQ-043: Reset pulse 10 cycles into a divide -> md_busy=0 immediately, no md_done pulse, state RUN.
